// File: rtl/tx_pattern_gen.sv
// Transmitter test-pattern source: PRBS7/15/31 or a fixed word, 16 bits per
// word clock, with optional inversion and single-bit error injection on dout[15].
module tx_pattern_gen #(
  parameter int W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cke,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  fixed_word,
  input  logic          inv,
  input  logic          inj_err,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  output logic [31:0]   word_cnt,
  output logic [15:0]   err_cnt
);

  localparam logic [1:0] MODE_FIXED = 2'd3;

  logic [30:0]  lfsr;
  logic [1:0]   mode_q;
  logic         inj_r;
  logic         inj_prev;
  logic         pending;

  logic [30:0]  mask;
  logic [30:0]  start;
  logic [30:0]  nxt;
  logic         reseed;
  logic [W-1:0] prbs_word;
  logic [W-1:0] pat_word;
  logic         out_bit;
  logic         fb;
  logic         inj_edge;
  logic         flip;

  // The active width doubles as the all-ones seed for each polynomial.
  always_comb begin
    case (mode)
      2'd0:    mask = 31'h0000_007F;
      2'd1:    mask = 31'h0000_7FFF;
      default: mask = 31'h7FFF_FFFF;
    endcase
  end

  assign reseed = (mode != mode_q) || ((lfsr & mask) == 31'd0);
  assign start  = reseed ? mask : lfsr;

  // Sixteen Fibonacci steps per word; the MSB is the serial bit, so the
  // first step lands in dout[W-1].
  always_comb begin
    nxt       = start;
    prbs_word = '0;
    out_bit   = 1'b0;
    fb        = 1'b0;
    for (int i = 0; i < W; i++) begin
      case (mode)
        2'd0: begin
          out_bit = nxt[6];
          fb      = nxt[6] ^ nxt[5];
        end
        2'd1: begin
          out_bit = nxt[14];
          fb      = nxt[14] ^ nxt[13];
        end
        default: begin
          out_bit = nxt[30];
          fb      = nxt[30] ^ nxt[27];
        end
      endcase
      prbs_word[W-1-i] = out_bit;
      nxt = {nxt[29:0], fb} & mask;
    end
  end

  assign pat_word = (mode == MODE_FIXED) ? fixed_word : prbs_word;
  assign inj_edge = inj_r & ~inj_prev;
  assign flip     = pending | inj_edge;

  // Edges seen while stalled are parked in pending and merged, so at most
  // one word is flipped per stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr       <= mask;
      mode_q     <= mode;
      inj_r      <= 1'b0;
      inj_prev   <= 1'b0;
      pending    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      word_cnt   <= 32'd0;
      err_cnt    <= 16'd0;
    end else begin
      inj_r    <= inj_err;
      inj_prev <= inj_r;
      if (cke) begin
        mode_q <= mode;
        if (mode != MODE_FIXED) begin
          lfsr <= nxt;
        end
        dout       <= pat_word ^ {W{inv}} ^ {flip, {(W-1){1'b0}}};
        dout_valid <= 1'b1;
        word_cnt   <= word_cnt + 32'd1;
        pending    <= 1'b0;
        if (flip && (err_cnt != 16'hFFFF)) begin
          err_cnt <= err_cnt + 16'd1;
        end
      end else if (inj_edge) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx_pattern_gen.sv
// Directed self-checking bench for tx_pattern_gen against a bit-serial
// recurrence model of each PRBS polynomial.
module tb_tx_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cke;
  logic [1:0]  mode;
  logic [15:0] fixed_word;
  logic        inv;
  logic        inj_err;
  logic [15:0] dout;
  logic        dout_valid;
  logic [31:0] word_cnt;
  logic [15:0] err_cnt;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          exp_cnt      = 0;
  int          zero_run     = 0;
  int          max_zero_run = 0;
  logic [15:0] last_exp     = '0;
  logic [15:0] exp_word;

  // Model history: m_hist[k] is serial bit b[n+k]; b[n+L] = b[n] ^ b[n+off].
  int          m_len;
  int          m_off;
  logic [30:0] m_hist;

  tx_pattern_gen #(.W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cke        (cke),
    .mode       (mode),
    .fixed_word (fixed_word),
    .inv        (inv),
    .inj_err    (inj_err),
    .dout       (dout),
    .dout_valid (dout_valid),
    .word_cnt   (word_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic c, input logic [1:0] m, input logic i, input logic e);
    cke     = c;
    mode    = m;
    inv     = i;
    inj_err = e;
  endtask

  task automatic modelSeed(input logic [1:0] md);
    case (md)
      2'd0:    begin m_len = 7;  m_off = 1; end
      2'd1:    begin m_len = 15; m_off = 1; end
      default: begin m_len = 31; m_off = 3; end
    endcase
    m_hist = '0;
    for (int k = 0; k < m_len; k++) m_hist[k] = 1'b1;
  endtask

  task automatic modelWord(output logic [15:0] w);
    logic nb;
    w = '0;
    for (int k = 0; k < 16; k++) begin
      w[15-k] = m_hist[0];
      nb = m_hist[0] ^ m_hist[m_off];
      m_hist = m_hist >> 1;
      m_hist[m_len-1] = nb;
    end
  endtask

  task automatic applyReset(input string tag);
    rst_n = 1'b0;
    tick();
    checkOutput({tag, "_dout"},     dout,       0);
    checkOutput({tag, "_valid"},    dout_valid, 0);
    checkOutput({tag, "_word_cnt"}, word_cnt,   0);
    checkOutput({tag, "_err_cnt"},  err_cnt,    0);
    rst_n   = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic runWords(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      modelWord(last_exp);
      exp_cnt++;
      checkOutput(tag, dout, last_exp);
      if (dout == 16'h0000) zero_run++;
      else zero_run = 0;
      if (zero_run > max_zero_run) max_zero_run = zero_run;
    end
  endtask

  task automatic stepWord(input string tag, input logic [15:0] hand);
    tick();
    modelWord(last_exp);
    exp_cnt++;
    checkOutput({tag, "_hand"},  dout, hand);
    checkOutput({tag, "_model"}, dout, last_exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    fixed_word = 16'hAAAA;
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b0);
    tick();
    applyReset("reset0");

    // Fixed word, then inverted, then a new word sampled on the fly
    tick();
    checkOutput("fixed_aaaa",  dout,       16'hAAAA);
    checkOutput("fixed_valid", dout_valid, 1);
    checkOutput("fixed_cnt1",  word_cnt,   1);
    inv = 1'b1;
    tick();
    checkOutput("fixed_inv", dout, 16'h5555);
    fixed_word = 16'h1234;
    inv = 1'b0;
    tick();
    checkOutput("fixed_1234", dout,     16'h1234);
    checkOutput("fixed_cnt3", word_cnt, 3);

    // PRBS7: hand-computed first words, period of 127 words
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    applyReset("reset_p7");
    modelSeed(2'd0);
    stepWord("prbs7_w0", 16'hFE04);
    checkOutput("prbs7_top7", dout[15:9], 7'h7F);
    stepWord("prbs7_w1", 16'h1851);
    runWords("prbs7_run", 125);
    stepWord("prbs7_w127", 16'hFE04);
    runWords("prbs7_run2", 127);
    checkOutput("prbs7_cnt", word_cnt, exp_cnt);

    // PRBS15: hand-computed first words, period of 32767 words
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyReset("reset_p15");
    modelSeed(2'd1);
    stepWord("prbs15_w0", 16'hFFFE);
    stepWord("prbs15_w1", 16'h0004);
    runWords("prbs15_run", 32765);
    stepWord("prbs15_w32767", 16'hFFFE);
    runWords("prbs15_run2", 20);

    // Stall mid-stream, then resume seamlessly
    cke = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput("stall_dout", dout,     last_exp);
      checkOutput("stall_cnt",  word_cnt, exp_cnt);
    end
    cke = 1'b1;
    runWords("prbs15_resume", 5);
    checkOutput("prbs15_resume_cnt", word_cnt, exp_cnt);

    // Mode 1 -> 0 restarts PRBS7 from its first word
    mode = 2'd0;
    modelSeed(2'd0);
    stepWord("switch_p7_w0", 16'hFE04);

    // Mode change under cke=0 waits for the next enabled cycle
    applyStimulus(1'b0, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("stall_mode_dout", dout,     16'hFE04);
      checkOutput("stall_mode_cnt",  word_cnt, exp_cnt);
    end
    cke = 1'b1;
    modelSeed(2'd2);
    stepWord("prbs31_w0", 16'hFFFF);
    zero_run     = 0;
    max_zero_run = 0;
    runWords("prbs31_run", 2000);
    checkOutput("prbs31_zero_run_gt2", (max_zero_run > 2), 0);
    checkOutput("prbs31_err_cnt0", err_cnt, 0);

    // Single injection: word k clean, word k+1 flipped in bit 15 only
    inj_err = 1'b1;
    tick();
    modelWord(last_exp);
    exp_cnt++;
    checkOutput("inj_word_k", dout, last_exp);
    inj_err = 1'b0;
    tick();
    modelWord(last_exp);
    exp_cnt++;
    checkOutput("inj_word_k1", dout, last_exp ^ 16'h8000);
    checkOutput("inj_err_cnt1", err_cnt, 1);
    runWords("inj_after", 4);
    checkOutput("inj_err_cnt1_hold", err_cnt, 1);

    // Two edges during a stall merge into one flipped word
    cke = 1'b0;
    inj_err = 1'b1; tick();
    inj_err = 1'b0; tick();
    inj_err = 1'b1; tick();
    inj_err = 1'b0; tick();
    tick();
    checkOutput("merge_stall_dout", dout,    last_exp);
    checkOutput("merge_stall_err",  err_cnt, 1);
    cke = 1'b1;
    tick();
    modelWord(last_exp);
    exp_cnt++;
    checkOutput("merge_flip", dout, last_exp ^ 16'h8000);
    runWords("merge_after", 3);
    checkOutput("merge_err_cnt2", err_cnt,  2);
    checkOutput("merge_word_cnt", word_cnt, exp_cnt);

    // Reset mid-operation with an injection in flight; replay must match
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    applyReset("reset_replay0");
    modelSeed(2'd1);
    runWords("replay_first", 500);
    inj_err = 1'b1;
    tick();
    inj_err = 1'b0;
    applyReset("reset_mid");
    modelSeed(2'd1);
    runWords("replay_second", 500);
    checkOutput("replay_err_cnt",  err_cnt,  0);
    checkOutput("replay_word_cnt", word_cnt, 500);
    checkOutput("replay_valid",    dout_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
